// File: rtl/shift_result_display_pkg.sv
// Shared constants for the shift-result display: segment codes and digit slot codes.
// Segment vectors are active-high, ordered {g,f,e,d,c,b,a}.
package shift_result_display_pkg;

  localparam int unsigned NumDigits = 4;

  // Every segment dark, before any output polarity is applied.
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Hex glyphs 0-9, A, b, C, d, E, F.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Which value each scan slot shows.
  typedef enum logic [1:0] {
    DigE   = 2'd0,
    DigB   = 2'd1,
    DigA   = 2'd2,
    DigCnt = 2'd3
  } digit_e;

endpackage

// File: rtl/shift_result_display_hex_to_7seg.sv
// Combinational hex nibble to seven-segment decoder.
// The output is active-high; the top module applies the board polarity.
module shift_result_display_hex_to_7seg
  import shift_result_display_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_HEX[hex_i];
  end

endmodule

// File: rtl/shift_result_display.sv
// Captures shifter operands and result, then time-multiplexes E, B, A and a load count
// onto a 4-digit seven-segment display.
module shift_result_display
  import shift_result_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a_i,
  input  logic [1:0] b_i,
  input  logic [3:0] e_i,
  input  logic       load_i,
  output logic [6:0] seg_o,
  output logic [3:0] an_o,
  output logic       valid_o
);

  localparam int unsigned DivW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(REFRESH_DIV - 1);
  localparam logic [6:0] SegOff  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] AnOff   = SEG_ACTIVE_LOW ? 4'hF : 4'h0;

  logic [DivW-1:0] div_q, div_d;
  digit_e          idx_q, idx_d;
  logic [3:0]      a_q, a_d;
  logic [1:0]      b_q, b_d;
  logic [3:0]      e_q, e_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            load_prev_q;
  logic            valid_q, valid_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;

  logic [3:0]      digit_val;
  logic [6:0]      glyph;
  logic [6:0]      seg_act;
  logic [3:0]      an_act;
  logic            blank;

  // Refresh divider and scan index.
  always_comb begin
    div_d = div_q;
    idx_d = idx_q;
    if (div_q == DivLast) begin
      div_d = '0;
      idx_d = digit_e'(idx_q + 2'd1);
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  // Capture registers and rising-edge load counter.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    e_d     = e_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      a_d     = a_i;
      b_d     = b_i;
      e_d     = e_i;
      valid_d = 1'b1;
    end
    if (load_i && !load_prev_q) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Digit content selection for the slot currently being scanned.
  always_comb begin
    digit_val = '0;
    unique case (idx_q)
      DigE:    digit_val = e_q;
      DigB:    digit_val = {2'b00, b_q};
      DigA:    digit_val = a_q;
      DigCnt:  digit_val = cnt_q;
      default: digit_val = '0;
    endcase
  end

  shift_result_display_hex_to_7seg u_hex_to_7seg (
    .hex_i (digit_val),
    .seg_o (glyph)
  );

  // Operand digits stay dark until something has been captured; the count always shows.
  always_comb begin
    blank   = !valid_q && (idx_q != DigCnt);
    seg_act = blank ? SEG_BLANK : glyph;
    an_act  = 4'b0001 << idx_q;
    seg_d   = SEG_ACTIVE_LOW ? ~seg_act : seg_act;
    an_d    = SEG_ACTIVE_LOW ? ~an_act : an_act;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q       <= '0;
      idx_q       <= DigE;
      a_q         <= '0;
      b_q         <= '0;
      e_q         <= '0;
      cnt_q       <= '0;
      load_prev_q <= 1'b0;
      valid_q     <= 1'b0;
      seg_q       <= SegOff;
      an_q        <= AnOff;
    end else begin
      div_q       <= div_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      e_q         <= e_d;
      cnt_q       <= cnt_d;
      load_prev_q <= load_i;
      valid_q     <= valid_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign seg_o   = seg_q;
  assign an_o    = an_q;
  assign valid_o = valid_q;

endmodule
